// File: rtl/br_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Define BTB_TAG_EN to store and compare tags; otherwise aliased PCs share an entry.
module br_target_buffer #(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES),
  parameter  int TAG_W   = 8,
  parameter  int CTR_W   = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      lookup_pc,
  output logic             predict,
  output logic [31:0]      pred_target,
  output logic [IDX_W-1:0] pred_index,
  input  logic             upd_en,
  input  logic [31:0]      upd_pc,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             flush_tbl
);

  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_ONE << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_ONE;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic             r_valid  [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [CTR_W-1:0] r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx;
  logic             w_lk_hit;
  logic             w_up_hit;
  logic             w_predict;
  logic             w_unused_pc;

  assign w_lk_idx = lookup_pc[IDX_W+1:2];

`ifdef BTB_TAG_EN
  logic [TAG_W-1:0] r_tag [ENTRIES];
  logic [TAG_W-1:0] w_lk_tag;
  logic [TAG_W-1:0] w_up_tag;

  assign w_lk_tag = lookup_pc[IDX_W+1+TAG_W:IDX_W+2];
  assign w_up_tag = upd_pc[IDX_W+1+TAG_W:IDX_W+2];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_up_hit = r_valid[upd_index] && (r_tag[upd_index] == w_up_tag);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) r_tag[i] <= '0;
    end else if (!flush_tbl && upd_en && !w_up_hit && upd_taken) begin
      r_tag[upd_index] <= w_up_tag;
    end
  end
`else
  logic w_unused_cfg;

  // Without tags an entry hits on valid alone; TAG_W has no effect.
  assign w_lk_hit     = r_valid[w_lk_idx];
  assign w_up_hit     = r_valid[upd_index];
  assign w_unused_cfg = (TAG_W > 0);
`endif

  // Bits outside the index/tag fields never take part in lookup or update.
  assign w_unused_pc = ^{lookup_pc, upd_pc};

  assign w_predict   = w_lk_hit && r_ctr[w_lk_idx][CTR_W-1];
  assign predict     = w_predict;
  assign pred_target = w_predict ? r_target[w_lk_idx] : 32'h0;
  assign pred_index  = w_lk_idx;

  // Flush only drops valid bits; counters and targets survive it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_target[i] <= 32'h0;
        r_ctr[i]    <= CTR_WNT;
      end
    end else if (flush_tbl) begin
      for (int i = 0; i < ENTRIES; i++) r_valid[i] <= 1'b0;
    end else if (upd_en) begin
      if (w_up_hit) begin
        if (upd_taken) begin
          if (r_ctr[upd_index] != CTR_MAX) r_ctr[upd_index] <= r_ctr[upd_index] + CTR_ONE;
          r_target[upd_index] <= upd_target;
        end else if (r_ctr[upd_index] != '0) begin
          r_ctr[upd_index] <= r_ctr[upd_index] - CTR_ONE;
        end
      end else if (upd_taken) begin
        r_valid[upd_index]  <= 1'b1;
        r_target[upd_index] <= upd_target;
        r_ctr[upd_index]    <= CTR_WT;
      end
    end
  end

endmodule

// File: tb/tb_br_target_buffer.sv
// Testbench for br_target_buffer: directed scenarios plus randomized traffic
// checked against a table model of valid/tag/target/counter per entry.
module tb_br_target_buffer;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
`ifdef BTB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic             CLK;
  logic             nRST;
  logic [31:0]      lookup_pc;
  logic             predict;
  logic [31:0]      pred_target;
  logic [IDX_W-1:0] pred_index;
  logic             upd_en;
  logic [31:0]      upd_pc;
  logic [IDX_W-1:0] upd_index;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             flush_tbl;

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_valid [ENTRIES];
  int          m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];

  br_target_buffer dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .lookup_pc  (lookup_pc),
    .predict    (predict),
    .pred_target(pred_target),
    .pred_index (pred_index),
    .upd_en     (upd_en),
    .upd_pc     (upd_pc),
    .upd_index  (upd_index),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .flush_tbl  (flush_tbl)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int tag_of(logic [31:0] pc);
    return int'((pc >> 6) & 32'hFF);
  endfunction

  function automatic bit m_hit(int i, logic [31:0] pc);
    return m_valid[i] && (!TAG_EN || m_tag[i] == tag_of(pc));
  endfunction

  // {predict, pred_target, pred_index} the model expects for a lookup
  function automatic logic [36:0] m_expect(logic [31:0] pc);
    int i;
    bit p;
    i = idx_of(pc);
    p = m_hit(i, pc) && (m_ctr[i] >= 2);
    return {p, (p ? m_tgt[i] : 32'h0), 4'(i)};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = 32'h0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic m_apply();
    int i;
    if (flush_tbl) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
    end else if (upd_en) begin
      i = int'(upd_index);
      if (m_hit(i, upd_pc)) begin
        if (upd_taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(upd_pc);
        m_tgt[i]   = upd_target;
        m_ctr[i]   = 2;
      end
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    m_apply();
    #1;
  endtask

  task automatic set_upd(bit en, logic [31:0] pc, bit tk, logic [31:0] tgt);
    upd_en     = en;
    upd_pc     = pc;
    upd_index  = pc[5:2];
    upd_taken  = tk;
    upd_target = tgt;
  endtask

  task automatic idle();
    upd_en    = 1'b0;
    flush_tbl = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
    m_reset();
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    lookup_pc = 32'h40;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    flush_tbl = 1'b0;
    m_reset();
    #12;
    n_tests++;
    if (predict !== 1'b0 || pred_target !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hold: predict=%0b target=%h, want 0/00000000", predict, pred_target);
    end
    nRST = 1'b1;
    #1;
    for (int a = 0; a <= 32'h3C; a += 4) begin
      lookup_pc = a;
      #1;
      n_tests++;
      if (predict !== 1'b0 || pred_target !== 32'h0 || pred_index !== 4'(a >> 2)) begin
        n_fail++;
        $display("FAIL reset_sweep pc=%h: predict=%0b target=%h index=%0d, want 0/0/%0d",
                 a, predict, pred_target, pred_index, a >> 2);
      end
    end
  endtask

  task automatic test_allocate();
    set_upd(1'b1, 32'h40, 1'b1, 32'h100);
    cycle();
    idle();
    lookup_pc = 32'h40;
    #1;
    n_tests++;
    if (predict !== 1'b1 || pred_target !== 32'h100 || pred_index !== 4'd0) begin
      n_fail++;
      $display("FAIL allocate: predict=%0b target=%h index=%0d, want 1/00000100/0",
               predict, pred_target, pred_index);
    end
  endtask

  // Starting from weakly taken: NT,NT,T,T,T,T(saturated),NT,NT
  task automatic test_counter();
    bit tk [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit ex [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 8; k++) begin
      set_upd(1'b1, 32'h40, tk[k], 32'h100);
      cycle();
      idle();
      lookup_pc = 32'h40;
      #1;
      n_tests++;
      if (predict !== ex[k] || pred_target !== (ex[k] ? 32'h100 : 32'h0)) begin
        n_fail++;
        $display("FAIL counter step %0d: predict=%0b target=%h, want %0b", k, predict, pred_target, ex[k]);
      end
    end
  endtask

  task automatic test_alias();
    bit          exp_p;
    logic [31:0] exp_t;
    do_reset();
    set_upd(1'b1, 32'h40, 1'b1, 32'h100);
    cycle();
    idle();
    exp_p = !TAG_EN;
    exp_t = TAG_EN ? 32'h0 : 32'h100;
    lookup_pc = 32'h80;
    #1;
    n_tests++;
    if (predict !== exp_p || pred_target !== exp_t) begin
      n_fail++;
      $display("FAIL alias: predict=%0b target=%h, want %0b/%h", predict, pred_target, exp_p, exp_t);
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_upd(1'b1, 32'h44, 1'b1, 32'h200);
    cycle();
    idle();
    lookup_pc = 32'h44;
    flush_tbl = 1'b1;
    set_upd(1'b1, 32'h44, 1'b1, 32'h300);
    #1;
    n_tests++;
    if (predict !== 1'b1 || pred_target !== 32'h200) begin
      n_fail++;
      $display("FAIL flush_pre: predict=%0b target=%h, want 1/00000200", predict, pred_target);
    end
    cycle();
    idle();
    for (int a = 0; a < ENTRIES; a++) begin
      lookup_pc = a * 4;
      #1;
      n_tests++;
      if (predict !== 1'b0 || pred_target !== 32'h0) begin
        n_fail++;
        $display("FAIL flush_sweep entry %0d: predict=%0b target=%h, want 0/0", a, predict, pred_target);
      end
    end
    set_upd(1'b1, 32'h44, 1'b1, 32'h300);
    cycle();
    idle();
    lookup_pc = 32'h44;
    #1;
    n_tests++;
    if (predict !== 1'b1 || pred_target !== 32'h300) begin
      n_fail++;
      $display("FAIL flush_realloc: predict=%0b target=%h, want 1/00000300", predict, pred_target);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_upd(1'b1, 32'h40, 1'b1, 32'h100);
    cycle();
    set_upd(1'b1, 32'h40, 1'b0, 32'h100);
    cycle();
    lookup_pc = 32'h40;
    set_upd(1'b1, 32'h40, 1'b1, 32'h140);
    #1;
    n_tests++;
    if (predict !== 1'b0 || pred_target !== 32'h0) begin
      n_fail++;
      $display("FAIL same_cycle_pre: predict=%0b target=%h, want 0/0", predict, pred_target);
    end
    cycle();
    idle();
    #1;
    n_tests++;
    if (predict !== 1'b1 || pred_target !== 32'h140) begin
      n_fail++;
      $display("FAIL same_cycle_post: predict=%0b target=%h, want 1/00000140", predict, pred_target);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_upd(1'b1, 32'h44, 1'b1, 32'h400);
    cycle();
    lookup_pc = 32'h44;
    set_upd(1'b1, 32'h48, 1'b1, 32'h500);
    #1;
    nRST = 1'b0;
    #1;
    n_tests++;
    if (predict !== 1'b0 || pred_target !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: predict=%0b target=%h, want 0/0", predict, pred_target);
    end
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    m_reset();
    idle();
    for (int k = 0; k < 2; k++) begin
      lookup_pc = (k == 0) ? 32'h44 : 32'h48;
      #1;
      n_tests++;
      if (predict !== 1'b0 || pred_target !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_mid_after pc=%h: predict=%0b target=%h, want 0/0", lookup_pc, predict, pred_target);
      end
    end
  endtask

  task automatic test_random();
    logic [36:0] exp;
    logic [31:0] pc;
    for (int n = 0; n < 400; n++) begin
      lookup_pc = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 2)) << 6) |
                  (32'($urandom_range(0, 15)) << 2);
      pc = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 2)) << 6) |
           (32'($urandom_range(0, 15)) << 2);
      set_upd($urandom_range(0, 1) == 1, pc, $urandom_range(0, 2) != 0, $urandom);
      flush_tbl = ($urandom_range(0, 31) == 0);
      #1;
      exp = m_expect(lookup_pc);
      n_tests++;
      if ({predict, pred_target, pred_index} !== exp) begin
        n_fail++;
        $display("FAIL random #%0d pc=%h: got p=%0b t=%h i=%0d, want p=%0b t=%h i=%0d",
                 n, lookup_pc, predict, pred_target, pred_index, exp[36], exp[35:4], exp[3:0]);
      end
      cycle();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_flush();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
